// File: rtl/shift_pipe_n.sv
// shift_pipe_n: parametrised multi-stage, multi-bit shift register.
// Shifts forward or backward, loads in parallel, has a clock enable and
// tracks how many stages have been written since the last reset or clear.
module shift_pipe_n #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int FW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin_fwd,
  input  logic [WIDTH-1:0]       sin_bwd,
  input  logic [WIDTH*DEPTH-1:0] pdata,
  output logic [WIDTH*DEPTH-1:0] q_par,
  output logic [WIDTH-1:0]       sout_fwd,
  output logic [WIDTH-1:0]       sout_bwd,
  output logic [FW-1:0]          fill,
  output logic                   primed
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_FWD  = 2'b01;
  localparam logic [1:0] MODE_BWD  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Fill value meaning "every stage holds written data".
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    fill_d;
  logic [FW-1:0]    fill_inc;
  logic             primed_q;
  logic             primed_d;

  // Saturating increment used by either shift direction.
  always_comb begin
    fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
  end

  // Next-state: clear beats enable, enable gates every mode.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    fill_d = fill_q;

    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = '0;
      end
      fill_d = '0;
    end else if (en) begin
      case (mode)
        MODE_FWD: begin
          stage_d[0] = sin_fwd;
          for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
          end
          fill_d = fill_inc;
        end
        MODE_BWD: begin
          stage_d[DEPTH-1] = sin_bwd;
          for (int i = 0; i < DEPTH - 1; i++) begin
            stage_d[i] = stage_q[i+1];
          end
          fill_d = fill_inc;
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = pdata[i*WIDTH +: WIDTH];
          end
          fill_d = FILL_FULL;
        end
        default: begin
          // MODE_HOLD: nothing changes.
        end
      endcase
    end

    // Registered so primed is a flop output rising with the fill edge.
    primed_d = (fill_d == FILL_FULL);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
      fill_q   <= fill_d;
      primed_q <= primed_d;
    end
  end

  // Pack stages onto the parallel output, stage i in slice i.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pack
    assign q_par[gi*WIDTH +: WIDTH] = stage_q[gi];
  end

  assign sout_fwd = stage_q[DEPTH-1];
  assign sout_bwd = stage_q[0];
  assign fill     = fill_q;
  assign primed   = primed_q;

endmodule

// File: tb/tb_shift_pipe_n.sv
// Testbench for shift_pipe_n: directed steps plus random traffic, all
// checked against a queue-based reference model.
module tb_shift_pipe_n;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int FW = $clog2(D + 1);

  logic           clk = 1'b0;
  logic           reset;
  logic           clr;
  logic           en;
  logic [1:0]     mode;
  logic [W-1:0]   sin_fwd;
  logic [W-1:0]   sin_bwd;
  logic [W*D-1:0] pdata;
  logic [W*D-1:0] q_par;
  logic [W-1:0]   sout_fwd;
  logic [W-1:0]   sout_bwd;
  logic [FW-1:0]  fill;
  logic           primed;

  int checks   = 0;
  int failures = 0;

  // Reference model: element 0 of the queue is stage 0.
  logic [W-1:0] model_q[$];
  int           model_fill;

  shift_pipe_n #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .en       (en),
    .mode     (mode),
    .sin_fwd  (sin_fwd),
    .sin_bwd  (sin_bwd),
    .pdata    (pdata),
    .q_par    (q_par),
    .sout_fwd (sout_fwd),
    .sout_bwd (sout_bwd),
    .fill     (fill),
    .primed   (primed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q = {};
    for (int i = 0; i < D; i++) model_q.push_back('0);
    model_fill = 0;
  endtask

  task automatic model_apply(input logic c, input logic e, input logic [1:0] m,
                             input logic [W-1:0] sf, input logic [W-1:0] sb,
                             input logic [W*D-1:0] pd);
    if (c) begin
      model_reset();
    end else if (e) begin
      case (m)
        2'b01: begin
          model_q.push_front(sf);
          void'(model_q.pop_back());
          model_fill = (model_fill + 1 > D) ? D : model_fill + 1;
        end
        2'b10: begin
          model_q.push_back(sb);
          void'(model_q.pop_front());
          model_fill = (model_fill + 1 > D) ? D : model_fill + 1;
        end
        2'b11: begin
          for (int i = 0; i < D; i++) model_q[i] = pd[i*W +: W];
          model_fill = D;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    logic [W*D-1:0] exp_par;
    for (int i = 0; i < D; i++) exp_par[i*W +: W] = model_q[i];
    check({tag, ".q_par"},    64'(q_par),    64'(exp_par));
    check({tag, ".sout_fwd"}, 64'(sout_fwd), 64'(model_q[D-1]));
    check({tag, ".sout_bwd"}, 64'(sout_bwd), 64'(model_q[0]));
    check({tag, ".fill"},     64'(fill),     64'(model_fill));
    check({tag, ".primed"},   64'(primed),   64'(model_fill == D));
  endtask

  // One clocked operation: drive, take the edge, update model, compare.
  task automatic step(input string tag, input logic c, input logic e, input logic [1:0] m,
                      input logic [W-1:0] sf, input logic [W-1:0] sb,
                      input logic [W*D-1:0] pd);
    clr = c; en = e; mode = m; sin_fwd = sf; sin_bwd = sb; pdata = pd;
    @(posedge clk);
    #1;
    model_apply(c, e, m, sf, sb, pd);
    check_model(tag);
    $display("step %-8s clr=%0b en=%0b mode=%0d q_par=%h fill=%0d primed=%0b",
             tag, c, e, m, q_par, fill, primed);
  endtask

  function automatic logic [W*D-1:0] rand_pd();
    logic [W*D-1:0] v;
    for (int i = 0; i < D; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  initial begin
    reset = 1'b1; clr = 1'b0; en = 1'b1; mode = 2'b11;
    sin_fwd = '0; sin_bwd = '0; pdata = '0;
    model_reset();

    // Reset held: random load attempts must not leak through.
    for (int k = 0; k < 3; k++) begin
      pdata = rand_pd(); sin_fwd = W'($urandom); sin_bwd = W'($urandom);
      @(posedge clk);
      #1;
      check("rst_hold", 64'({q_par, fill, primed}), 64'(0));
    end
    #2 reset = 1'b0;

    // First edge after reset release takes effect: load, then async reset mid-cycle.
    step("load0", 1'b0, 1'b1, 2'b11, '0, '0, 32'hDEADBEEF);
    check("load0.const", 64'(q_par), 64'h00000000DEADBEEF);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_rst.q_par", 64'(q_par), 64'(0));
    check("async_rst.fill",  64'({fill, primed}), 64'(0));
    #2 reset = 1'b0;

    // Forward delay line.
    step("fwd1", 1'b0, 1'b1, 2'b01, 8'h11, '0, '0);
    step("fwd2", 1'b0, 1'b1, 2'b01, 8'h22, '0, '0);
    step("fwd3", 1'b0, 1'b1, 2'b01, 8'h33, '0, '0);
    check("fwd3.primed", 64'(primed), 64'(0));
    step("fwd4", 1'b0, 1'b1, 2'b01, 8'h44, '0, '0);
    check("fwd4.const_qpar", 64'(q_par), 64'h11223344);
    check("fwd4.const_sout", 64'(sout_fwd), 64'h11);
    check("fwd4.const_fill", 64'({fill, primed}), 64'({3'd4, 1'b1}));

    // Load then backward shifts.
    step("load1", 1'b0, 1'b1, 2'b11, '0, '0, 32'hA1B2C3D4);
    step("bwd1", 1'b0, 1'b1, 2'b10, '0, 8'hEE, '0);
    check("bwd1.const_sout", 64'(sout_bwd), 64'hC3);
    step("bwd2", 1'b0, 1'b1, 2'b10, '0, 8'hEE, '0);
    check("bwd2.const_sout", 64'(sout_bwd), 64'hB2);
    check("bwd2.const_qpar", 64'(q_par), 64'hEEEEA1B2);
    check("bwd2.const_fill", 64'(fill), 64'd4);

    // Enable gaps and hold cycles in a forward stream from a cleared state.
    step("clr0", 1'b1, 1'b1, 2'b01, '0, '0, '0);
    step("gap1", 1'b0, 1'b1, 2'b01, 8'h51, '0, '0);
    step("gap2", 1'b0, 1'b0, 2'b01, 8'h99, '0, '0);
    step("gap3", 1'b0, 1'b1, 2'b00, 8'h98, '0, '0);
    step("gap4", 1'b0, 1'b1, 2'b01, 8'h52, '0, '0);
    step("gap5", 1'b0, 1'b0, 2'b11, 8'h97, '0, 32'hFFFFFFFF);
    step("gap6", 1'b0, 1'b1, 2'b01, 8'h53, '0, '0);
    step("gap7", 1'b0, 1'b1, 2'b01, 8'h54, '0, '0);
    check("gap7.const_qpar", 64'(q_par), 64'h51525354);

    // Clear beats load and a low enable.
    step("load2", 1'b0, 1'b1, 2'b11, '0, '0, 32'h13579BDF);
    step("clrprio", 1'b1, 1'b0, 2'b11, '0, '0, 32'h2468ACE0);
    check("clrprio.const", 64'({q_par, fill, primed}), 64'(0));
    for (int k = 0; k < 3; k++) step("post_clr", 1'b0, 1'b1, 2'b01, W'($urandom), '0, '0);
    check("post_clr.const", 64'({fill, primed}), 64'({3'd3, 1'b0}));

    // Saturation with alternating direction.
    step("clr1", 1'b1, 1'b1, 2'b00, '0, '0, '0);
    for (int k = 0; k < 10; k++) begin
      step("alt", 1'b0, 1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, W'($urandom), W'($urandom), '0);
      check("alt.fill_bound", 64'(fill <= FW'(D)), 64'(1));
    end

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
           2'($urandom), W'($urandom), W'($urandom), rand_pd());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
